// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the ALUControl decoder.
package mdu_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } mdu_state_e;

   localparam int MDU_WIDTH = 32;

   localparam logic [5:0] FUNCT_MUL  = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1a;
   localparam logic [5:0] FUNCT_MFHI = 6'h10;
   localparam logic [5:0] FUNCT_MFLO = 6'h12;
endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the pipeline (master) and the multiply/divide unit (slave).
// MDU_UNSIGNED_EN adds the is_unsigned request bit.
interface mult_div_unit_if import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH
);
   logic             start;
   logic             is_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MDU_UNSIGNED_EN
   logic             is_unsigned;

   modport master (output start, is_div, a, b, is_unsigned, input busy, done, hi, lo);
   modport slave  (input start, is_div, a, b, is_unsigned, output busy, done, hi, lo);
`else
   modport master (output start, is_div, a, b, input busy, done, hi, lo);
   modport slave  (input start, is_div, a, b, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign repair.
module mdu_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);
   assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-step signed multiply / restoring divide producing HI/LO.
// MDU_UNSIGNED_EN adds the is_unsigned request bit (multu/divu semantics).
module mult_div_unit import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   mult_div_unit_if.slave   bus
);
   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;

   logic               uns;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
   logic               q_bit;
   logic [2*WIDTH-1:0] iter_acc, prod_fixed;
   logic [WIDTH-1:0]   quot_fixed, rem_fixed;

`ifdef MDU_UNSIGNED_EN
   assign uns = bus.is_unsigned;
`else
   assign uns = 1'b0;
`endif

   mdu_sign_fix #(.W(WIDTH)) u_abs_a (
      .val_i (bus.a), .neg_i (~uns & bus.a[WIDTH-1]), .val_o (a_abs));
   mdu_sign_fix #(.W(WIDTH)) u_abs_b (
      .val_i (bus.b), .neg_i (~uns & bus.b[WIDTH-1]), .val_o (b_abs));
   mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
      .val_i (acc_q), .neg_i (neg_res_q), .val_o (prod_fixed));
   mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
      .val_i (acc_q[WIDTH-1:0]), .neg_i (neg_res_q), .val_o (quot_fixed));
   mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
      .val_i (acc_q[2*WIDTH-1:WIDTH]), .neg_i (neg_rem_q), .val_o (rem_fixed));

   // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
   assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff = rem_sh - {1'b0, op_q};
   assign q_bit    = ~div_diff[WIDTH];
   assign iter_acc = is_div_q
                   ? {(q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit}
                   : {mul_sum, acc_q[WIDTH-1:1]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      op_d      = op_q;
      acc_d     = acc_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = CALC;
               cnt_d     = '0;
               busy_d    = 1'b1;
               is_div_d  = bus.is_div;
               neg_res_d = ~uns & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               neg_rem_d = ~uns & bus.a[WIDTH-1];
               div0_d    = (bus.b == '0);
               op_d      = bus.is_div ? b_abs : a_abs;
               acc_d     = {{WIDTH{1'b0}}, (bus.is_div ? a_abs : b_abs)};
            end
         end
         CALC: begin
            acc_d = iter_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (is_div_q) begin
               // Divide by zero: quotient forced to all ones, remainder already restores a
               hi_d = rem_fixed;
               lo_d = div0_q ? '1 : quot_fixed;
            end else begin
               {hi_d, lo_d} = prod_fixed;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results, divide by zero, ignore and reset.
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic issue(input logic div, input logic [31:0] av, input logic [31:0] bv,
                        input logic uns);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.is_div = div;
      bus.a      = av;
      bus.b      = bv;
`ifdef MDU_UNSIGNED_EN
      bus.is_unsigned = uns;
`else
      if (uns) $display("note: unsigned request issued on a signed-only build");
`endif
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts rising edges after the issue edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      lat = -1;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            lat = n;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_mul_signed();
      int lat;
      issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mul_busy_start: got %b expected 1", bus.busy); end
      wait_done(lat);
      checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hi: got %h expected ffffffff", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_lo: got %h expected ffffffeb", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b expected 0", bus.busy); end
      @(posedge clk);
      #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_width: got %b expected 0", bus.done); end
      issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      wait_done(lat);
      checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mul_neg1x2: got %h expected fffffffffffffffe", {bus.hi, bus.lo}); end
   endtask

   task automatic test_div_signed();
      int lat;
      issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      wait_done(lat);
      checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
      checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
      issue(1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);
      wait_done(lat);
      checks++; if ({bus.hi, bus.lo} !== {32'h0000_0002, 32'hFFFF_FFF2}) begin errors++; $display("FAIL div_100_by_m7: got %h expected 00000002fffffff2", {bus.hi, bus.lo}); end
   endtask

   task automatic test_overflow();
      int lat;
      issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_done(lat);
      checks++; if (bus.hi !== 32'h4000_0000) begin errors++; $display("FAIL minmul_hi: got %h expected 40000000", bus.hi); end
      checks++; if (bus.lo !== 32'h0000_0000) begin errors++; $display("FAIL minmul_lo: got %h expected 00000000", bus.lo); end
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_done(lat);
      checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL mindiv_lo: got %h expected 80000000", bus.lo); end
      checks++; if (bus.hi !== 32'h0000_0000) begin errors++; $display("FAIL mindiv_hi: got %h expected 00000000", bus.hi); end
   endtask

   task automatic test_div_zero();
      int lat;
      issue(1'b1, 32'h0000_0005, 32'h0000_0000, 1'b0);
      wait_done(lat);
      checks++; if (lat != 33) begin errors++; $display("FAIL div0_latency: got %0d expected 33", lat); end
      checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", bus.lo); end
      checks++; if (bus.hi !== 32'h0000_0005) begin errors++; $display("FAIL div0_hi: got %h expected 00000005", bus.hi); end
      issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0);
      wait_done(lat);
      checks++; if ({bus.hi, bus.lo} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div0_neg: got %h expected fffffff9ffffffff", {bus.hi, bus.lo}); end
   endtask

   task automatic test_ignore_and_abort();
      int lat;
      int dones;
      issue(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
      repeat (4) @(negedge clk);
      bus.start  = 1'b1;
      bus.is_div = 1'b1;
      bus.a      = 32'h0000_0064;
      bus.b      = 32'h0000_0007;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      checks++; if ({bus.hi, bus.lo} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin errors++; $display("FAIL hold_during_calc: got %h expected fffffff9ffffffff", {bus.hi, bus.lo}); end
      wait_done(lat);
      checks++; if (lat != 29) begin errors++; $display("FAIL ignore_latency: got %0d expected 29", lat); end
      checks++; if ({bus.hi, bus.lo} !== {32'h0, 32'h0000_000C}) begin errors++; $display("FAIL ignore_result: got %h expected 000000000000000c", {bus.hi, bus.lo}); end
      @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_queue: got busy %b expected 0", bus.busy); end

      issue(1'b1, 32'h0000_0064, 32'h0000_0007, 1'b0);
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
      checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo: got %h expected 0", {bus.hi, bus.lo}); end
      @(negedge clk);
      reset_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) dones++;
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(1'b0, 32'h0000_0006, 32'h0000_0007, 1'b0);
      wait_done(lat);
      checks++; if (bus.lo !== 32'h0000_002A) begin errors++; $display("FAIL b2b_first: got %h expected 0000002a", bus.lo); end
      issue(1'b1, 32'h0000_0064, 32'h0000_0007, 1'b0);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b expected 1", bus.busy); end
      wait_done(lat);
      checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
      checks++; if ({bus.hi, bus.lo} !== {32'h0000_0002, 32'h0000_000E}) begin errors++; $display("FAIL b2b_result: got %h expected 000000020000000e", {bus.hi, bus.lo}); end
   endtask

`ifdef MDU_UNSIGNED_EN
   task automatic test_unsigned();
      int lat;
      issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      wait_done(lat);
      checks++; if ({bus.hi, bus.lo} !== {32'h0000_0001, 32'hFFFF_FFFE}) begin errors++; $display("FAIL multu: got %h expected 00000001fffffffe", {bus.hi, bus.lo}); end
      issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
      wait_done(lat);
      checks++; if ({bus.hi, bus.lo} !== {32'h0000_0001, 32'h7FFF_FFFF}) begin errors++; $display("FAIL divu: got %h expected 000000017fffffff", {bus.hi, bus.lo}); end
      issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1);
      wait_done(lat);
      checks++; if ({bus.hi, bus.lo} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_zero: got %h expected fffffff9ffffffff", {bus.hi, bus.lo}); end
      bus.is_unsigned = 1'b0;
   endtask
`endif

   initial begin
      bus.start  = 1'b0;
      bus.is_div = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
`ifdef MDU_UNSIGNED_EN
      bus.is_unsigned = 1'b0;
`endif
      test_reset();
      test_mul_signed();
      test_div_signed();
      test_overflow();
      test_div_zero();
      test_ignore_and_abort();
      test_back_to_back();
`ifdef MDU_UNSIGNED_EN
      test_unsigned();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide responder for the CPU datapath. It executes the mul/div operations that ALUControl decodes from funct codes 0x18 and 0x1a.
- Holds HI/LO for mfhi (0x10) and mflo (0x12).
- The pipeline issues with start/is_div. The unit raises busy, computes over 32 iterations and pulses done. The pipeline stalls mfhi/mflo while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  issue request; sampled only when busy=0.
- is_div  input  1  0=mul, 1=div; sampled with start.
- a  input  WIDTH  rs operand (multiplicand/dividend).
- b  input  WIDTH  rt operand (multiplier/divisor).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO are updated.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).
- is_unsigned  input  1  present only with MDU_UNSIGNED_EN.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter=0.
  - Reset mid-operation aborts it: no done pulse, HI/LO cleared.
- States:
  - IDLE: if start=1, latch |a|, |b|, the result sign, the remainder sign and is_div; go to CALC with count=0; busy=1 from the next cycle.
  - CALC: one iteration per cycle, 32 cycles (count 0..31), then go to FIX.
    - mul: shift-add over a 2*WIDTH accumulator.
    - div: restoring shift-subtract producing quotient and remainder.
  - FIX: apply two's-complement sign correction, write hi/lo, done=1 for this one cycle, busy=0, go to IDLE.
- Latency: start sampled at edge E0; CALC spans E1..E32; hi/lo/done update at E33.
  - busy is high from after E0 until after E33.
  - done is high for exactly the cycle after E33.
- hi/lo hold their previous values throughout CALC. They change only at FIX or on reset.
- start while busy=1 is ignored; no queuing.
- Signed rules:
  - Product is the full 64-bit signed value.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural wrap; no trap.
- Divide by zero: the full 33-cycle latency still applies; lo=all ones, hi=a (the original dividend, unmodified).
- Back-to-back: start may be asserted in the same cycle that done=1. The unit is IDLE then, so it is accepted.

Optional Feature:
- Macro: MDU_UNSIGNED_EN.
- Defined:
  - Adds port is_unsigned, sampled with start.
  - When is_unsigned=1, operands are not absolute-valued and FIX applies no sign correction (multu/divu semantics).
  - Divide-by-zero rule is unchanged.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Shared package mdu_pkg:
  - state enum (IDLE, CALC, FIX)
  - WIDTH default
  - funct constants FUNCT_MUL=6'h18, FUNCT_DIV=6'h1a, FUNCT_MFHI=6'h10, FUNCT_MFLO=6'h12, shared with ALUControl
- One sub-module, mdu_sign_fix (combinational): conditional two's-complement negate of a WIDTH value. Instantiated for operand abs and result fix.

Test Plan:
- mul a=7, b=0xFFFFFFFD (-3) -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly 1 cycle.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- mul a=b=0x80000000 -> hi=0x40000000, lo=0x00000000; then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div a=5, b=0 -> lo=0xFFFFFFFF, hi=0x00000005 at cycle 33.
- Issue mul 3*4, pulse start again with div at cycle 5 -> second request ignored; hi=0, lo=12.
  - Then start a new op and drop reset_n at cycle 10 -> busy=0, hi=lo=0 next cycle, no done.
- With MDU_UNSIGNED_EN, is_unsigned=1: mul 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE; divu 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
